// File: rtl/hamming_secded_codec.sv
// Parametrised SEC-DED Hamming codec with a registered valid/ready stage.
// Each accepted word is either encoded or decoded/corrected, as chosen by select.
// Two saturating counters track corrected and uncorrectable decodes.
module hamming_secded_codec #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8,
    // Smallest r with 2^r >= DATA_W + r + 1, valid for DATA_W in 1..57
    localparam int unsigned PAR_W  = (DATA_W <= 1)  ? 2 :
                                     (DATA_W <= 4)  ? 3 :
                                     (DATA_W <= 11) ? 4 :
                                     (DATA_W <= 26) ? 5 : 6,
    localparam int unsigned CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              select,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_data,
    output logic [1:0]        out_status,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam logic [1:0] ST_CLEAN   = 2'b00;
    localparam logic [1:0] ST_CORR    = 2'b01;
    localparam logic [1:0] ST_UNCORR  = 2'b10;
    localparam logic [1:0] ST_OVERALL = 2'b11;

    // Hamming positions that are powers of two hold parity, the rest hold payload
    function automatic logic is_pow2(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

    function automatic logic [CODE_W-1:0] encode_word(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic              p;
        int                j;
        c = '0;
        j = 0;
        for (int pos = 1; pos < int'(CODE_W); pos++) begin
            if (!is_pow2(pos)) begin
                c[pos-1] = d[j];
                j++;
            end
        end
        // Parity positions never cover each other, so filling them in order is safe
        for (int k = 0; k < int'(PAR_W); k++) begin
            p = 1'b0;
            for (int pos = 1; pos < int'(CODE_W); pos++) begin
                if (((pos >> k) & 1) == 1) begin
                    p = p ^ c[pos-1];
                end
            end
            c[(1 << k) - 1] = p;
        end
        c[CODE_W-1] = ^c[CODE_W-2:0];
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int                j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < int'(CODE_W); pos++) begin
            if (!is_pow2(pos)) begin
                d[j] = c[pos-1];
                j++;
            end
        end
        return d;
    endfunction

    function automatic int syndrome(input logic [CODE_W-1:0] c);
        int s;
        s = 0;
        for (int pos = 1; pos < int'(CODE_W); pos++) begin
            if (c[pos-1]) begin
                s = s ^ pos;
            end
        end
        return s;
    endfunction

    logic              accept;
    int                syn;
    logic              pb;
    logic [CODE_W-1:0] fixed_word;
    logic [DATA_W-1:0] dec_data;
    logic [1:0]        dec_status;
    logic [CODE_W-1:0] nxt_data;
    logic [1:0]        nxt_status;
    logic              corr_inc;
    logic              uncorr_inc;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Syndrome decode and single-bit correction of the incoming codeword
    always_comb begin
        syn        = syndrome(in_data);
        pb         = ^in_data;
        fixed_word = in_data;
        for (int pos = 1; pos < int'(CODE_W); pos++) begin
            if (pos == syn) begin
                fixed_word[pos-1] = ~in_data[pos-1];
            end
        end
        dec_data   = extract_data(in_data);
        dec_status = ST_CLEAN;
        if (syn != 0 && pb) begin
            // A syndrome beyond the last position cannot come from one flipped bit
            if (syn >= int'(CODE_W)) begin
                dec_status = ST_UNCORR;
            end else begin
                dec_data   = extract_data(fixed_word);
                dec_status = ST_CORR;
            end
        end else if (syn == 0 && pb) begin
            dec_status = ST_OVERALL;
        end else if (syn != 0) begin
            dec_status = ST_UNCORR;
        end
    end

    // Select the result for the current mode and the counter increments
    always_comb begin
        nxt_data   = encode_word(in_data[DATA_W-1:0]);
        nxt_status = ST_CLEAN;
        if (select) begin
            nxt_data   = CODE_W'(dec_data);
            nxt_status = dec_status;
        end
        corr_inc   = accept && select &&
                     (dec_status == ST_CORR || dec_status == ST_OVERALL);
        uncorr_inc = accept && select && (dec_status == ST_UNCORR);
    end

    // Output register: load on accept, drop valid once consumed with nothing new
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_status <= ST_CLEAN;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= nxt_data;
            out_status <= nxt_status;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Saturating error counters; clear beats a simultaneous increment
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (corr_inc && corr_cnt != '1) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
            if (uncorr_inc && uncorr_cnt != '1) begin
                uncorr_cnt <= uncorr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Self-checking bench: a DATA_W=4/CNT_W=2 instance for directed cases and
// a DATA_W=11 instance for randomized round trips and a handshake scoreboard.
module tb_hamming_secded_codec;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance a: DATA_W=4, CODE_W=8, CNT_W=2
    logic       a_sel, a_iv, a_ir, a_ov, a_or, a_clr;
    logic [7:0] a_id, a_od;
    logic [1:0] a_st, a_cc, a_uc;

    // Instance b: DATA_W=11, CODE_W=16, CNT_W=8
    logic        b_sel, b_iv, b_ir, b_ov, b_or, b_clr;
    logic [15:0] b_id, b_od;
    logic [1:0]  b_st;
    logic [7:0]  b_cc, b_uc;

    hamming_secded_codec #(.DATA_W(4), .CNT_W(2)) u_a (
        .clk(clk), .rst(rst), .select(a_sel), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .out_status(a_st), .clr_cnt(a_clr), .corr_cnt(a_cc), .uncorr_cnt(a_uc)
    );

    hamming_secded_codec #(.DATA_W(11), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .select(b_sel), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .out_status(b_st), .clr_cnt(b_clr), .corr_cnt(b_cc), .uncorr_cnt(b_uc)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder: parity bits are chosen so the syndrome of the full word is zero
    function automatic logic [63:0] m_encode(input int cw, input logic [63:0] d);
        logic [63:0] c;
        int          s;
        int          j;
        c = '0;
        s = 0;
        j = 0;
        for (int pos = 1; pos < cw; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (d[j]) begin
                    c[pos-1] = 1'b1;
                    s = s ^ pos;
                end
                j++;
            end
        end
        for (int k = 0; (1 << k) < cw; k++) begin
            c[(1 << k) - 1] = s[k];
        end
        c[cw-1] = ^c;
        return c;
    endfunction

    function automatic logic [63:0] m_extract(input int cw, input logic [63:0] c);
        logic [63:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < cw; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = c[pos-1];
                j++;
            end
        end
        return d;
    endfunction

    // One transaction with out_ready high; result visible at the following negedge
    task automatic a_xfer(input logic sel, input logic [7:0] din, input logic clr);
        @(negedge clk);
        a_sel = sel;
        a_id  = din;
        a_iv  = 1'b1;
        a_clr = clr;
        @(negedge clk);
        a_iv  = 1'b0;
        a_clr = 1'b0;
    endtask

    task automatic b_xfer(input logic sel, input logic [15:0] din);
        @(negedge clk);
        b_sel = sel;
        b_id  = din;
        b_iv  = 1'b1;
        @(negedge clk);
        b_iv  = 1'b0;
    endtask

    logic [7:0]  dec_codes [4] = '{8'h55, 8'h51, 8'hD5, 8'h56};
    logic [1:0]  dec_st    [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0]  dec_cc    [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [1:0]  dec_uc    [4] = '{2'd0, 2'd0, 2'd0, 2'd1};

    logic [17:0] sbq [$];

    initial begin
        logic [15:0] d, code, flip, w0, w1;
        logic [17:0] exp;
        int          ncorr, nunc, i, j, nflip, sent, rcvd, cycles;

        rst = 1'b1;
        a_sel = 0; a_iv = 0; a_id = '0; a_or = 1; a_clr = 0;
        b_sel = 0; b_iv = 0; b_id = '0; b_or = 1; b_clr = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", a_ov, 0);
        check("rst_out_data", a_od, 0);
        check("rst_status", a_st, 0);
        check("rst_corr_cnt", a_cc, 0);
        check("rst_uncorr_cnt", a_uc, 0);
        check("rst_in_ready", a_ir, 1);

        // Directed encode of 4'b1011
        a_xfer(1'b0, 8'h0B, 1'b0);
        check("enc_valid", a_ov, 1);
        check("enc_data_const", a_od, 8'h55);
        check("enc_data_model", a_od, m_encode(8, 64'hB));
        check("enc_status", a_st, 0);
        check("enc_in_ready", a_ir, 1);

        // Directed decodes
        for (int k = 0; k < 4; k++) begin
            a_xfer(1'b1, dec_codes[k], 1'b0);
            check("dec_valid", a_ov, 1);
            check("dec_status", a_st, dec_st[k]);
            check("dec_corr_cnt", a_cc, dec_cc[k]);
            check("dec_uncorr_cnt", a_uc, dec_uc[k]);
            if (dec_st[k] != 2'b10) check("dec_data", a_od, 8'h0B);
            else check("dec_raw_data", a_od, m_extract(8, 64'(dec_codes[k])));
        end

        // Saturation with a 2-bit counter, then clear racing an increment
        a_xfer(1'b1, 8'h55, 1'b1);
        check("clr_corr", a_cc, 0);
        check("clr_uncorr", a_uc, 0);
        for (int k = 0; k < 5; k++) begin
            a_xfer(1'b1, 8'h51, 1'b0);
            check("sat_corr", a_cc, (k + 1 > 3) ? 3 : k + 1);
        end
        a_xfer(1'b1, 8'h51, 1'b1);
        check("clr_wins", a_cc, 0);
        check("clr_status", a_st, 2'b01);

        // Reset while a word is held under backpressure
        a_xfer(1'b1, 8'h51, 1'b0);
        check("pre_rst_corr", a_cc, 1);
        @(negedge clk);
        a_or = 1'b0;
        a_sel = 1'b1; a_id = 8'h56; a_iv = 1'b1;
        @(negedge clk);
        a_iv = 1'b0;
        check("pre_rst_valid", a_ov, 1);
        check("pre_rst_uncorr", a_uc, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", a_ov, 0);
        check("mid_rst_data", a_od, 0);
        check("mid_rst_corr", a_cc, 0);
        check("mid_rst_uncorr", a_uc, 0);
        a_or = 1'b1;

        // DATA_W=11 round trips with every single flip and one double flip
        ncorr = 0;
        nunc  = 0;
        for (int n = 0; n < 20; n++) begin
            d    = 16'($urandom_range(0, 2047));
            code = 16'(m_encode(16, 64'(d)));
            b_xfer(1'b0, d);
            check("rt_enc_data", b_od, code);
            check("rt_enc_status", b_st, 0);
            b_xfer(1'b1, code);
            check("rt_clean_data", b_od, d);
            check("rt_clean_status", b_st, 0);
            for (int b = 0; b < 16; b++) begin
                flip = 16'(1) << b;
                b_xfer(1'b1, code ^ flip);
                check("sgl_data", b_od, d);
                check("sgl_status", b_st, (b == 15) ? 2'b11 : 2'b01);
                ncorr++;
            end
            i = $urandom_range(0, 15);
            j = (i + $urandom_range(1, 15)) % 16;
            flip = (16'(1) << i) | (16'(1) << j);
            b_xfer(1'b1, code ^ flip);
            check("dbl_status", b_st, 2'b10);
            check("dbl_raw_data", b_od, m_extract(16, 64'(code ^ flip)));
            nunc++;
        end
        check("rt_corr_cnt", b_cc, (ncorr > 255) ? 255 : ncorr);
        check("rt_uncorr_cnt", b_uc, nunc);

        // Directed backpressure hold
        w0 = 16'($urandom_range(0, 2047));
        w1 = 16'($urandom_range(0, 2047));
        @(negedge clk);
        b_or = 1'b0; b_sel = 1'b0; b_id = w0; b_iv = 1'b1;
        @(negedge clk);
        b_id = w1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_in_ready", b_ir, 0);
            check("bp_valid", b_ov, 1);
            check("bp_hold", b_od, m_encode(16, 64'(w0)));
            @(negedge clk);
        end
        b_or = 1'b1;
        #1;
        check("bp_release_ready", b_ir, 1);
        @(negedge clk);
        b_iv = 1'b0;
        check("bp_next_word", b_od, m_encode(16, 64'(w1)));
        @(negedge clk);

        // Random handshake scoreboard: 100 mixed words, random stalls
        sent = 0;
        rcvd = 0;
        cycles = 0;
        while ((sent < 100 || sbq.size() != 0) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            b_or = ($urandom_range(0, 3) != 0);
            if (sent < 100) begin
                b_iv  = ($urandom_range(0, 2) != 0);
                b_sel = 1'($urandom_range(0, 1));
                d     = 16'($urandom_range(0, 2047));
                code  = 16'(m_encode(16, 64'(d)));
                nflip = $urandom_range(0, 2);
                i     = $urandom_range(0, 15);
                j     = (i + $urandom_range(1, 15)) % 16;
                flip  = '0;
                if (nflip >= 1) flip = flip | (16'(1) << i);
                if (nflip == 2) flip = flip | (16'(1) << j);
                if (!b_sel) begin
                    b_id = d;
                    exp  = {2'b00, code};
                end else begin
                    b_id = code ^ flip;
                    if (nflip == 0) exp = {2'b00, d};
                    else if (nflip == 1) exp = {(i == 15) ? 2'b11 : 2'b01, d};
                    else exp = {2'b10, 16'(m_extract(16, 64'(code ^ flip)))};
                end
            end else begin
                b_iv = 1'b0;
            end
            #1;
            if (b_ov && b_or) begin
                if (sbq.size() == 0) begin
                    check("sb_underflow", sbq.size(), 1);
                end else begin
                    check("sb_word", {b_st, b_od}, sbq.pop_front());
                end
                rcvd++;
            end
            if (b_iv && b_ir) begin
                sbq.push_back(exp);
                sent++;
            end
        end
        check("sb_sent", sent, 100);
        check("sb_received", rcvd, 100);
        check("sb_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
